// File: rtl/mem_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : mem_pkg
// Purpose : Shared types and default constants for the memory responder.
//           Holds the responder state encoding and the default fill byte
//           and write-protect limit.
// Ports   : none (package)
// Macros  : none
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
package mem_pkg;

   // Responder phases: wipe the array, accept the program image, then serve
   // the controller. The encoding is fixed at 2 bits.
   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SERVE = 2'd2
   } mem_state_t;

   // 8'hFF is a no-op opcode for the controller, so an early fetch is harmless.
   localparam logic [7:0] c_default_fill_byte = 8'hFF;

   // First writable address when write protection is compiled in.
   localparam logic [7:0] c_default_wp_limit = 8'h10;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_responder_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : mem_responder_if
// Purpose : Bundles the controller memory bus and the program-load byte
//           stream that connect to the memory responder.
// Ports   : (interface signals)
//           address    controller access address
//           to_mem     controller write data
//           from_mem   read data returned to the controller
//           mem_clock  controller access strobe (level)
//           mem_write  write qualifier, sampled with the strobe edge
//           load_valid load byte present
//           load_data  load byte
//           load_last  final load byte (qualified by load_valid)
//           load_ready responder accepts a load byte this cycle
//           mem_ready  responder is serving controller accesses
//           wp_fault   sticky write-protect violation
//           Modports: master (controller/loader side), slave (responder).
// Macros  : none
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
interface mem_responder_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) ();

   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] to_mem;
   logic [DATA_W-1:0] from_mem;
   logic              mem_clock;
   logic              mem_write;
   logic              load_valid;
   logic [DATA_W-1:0] load_data;
   logic              load_last;
   logic              load_ready;
   logic              mem_ready;
   logic              wp_fault;

   modport master (
      output address,
      output to_mem,
      output mem_clock,
      output mem_write,
      output load_valid,
      output load_data,
      output load_last,
      input  from_mem,
      input  load_ready,
      input  mem_ready,
      input  wp_fault
   );

   modport slave (
      input  address,
      input  to_mem,
      input  mem_clock,
      input  mem_write,
      input  load_valid,
      input  load_data,
      input  load_last,
      output from_mem,
      output load_ready,
      output mem_ready,
      output wp_fault
   );

endinterface : mem_responder_if
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : mem_array
// Purpose : 2^ADDR_W x DATA_W storage with one synchronous write port and one
//           asynchronous (combinational) read port. Contents are not reset;
//           the owner is expected to initialise them.
// Ports   : clock    write clock (posedge)
//           i_we     write enable
//           i_waddr  write address
//           i_wdata  write data
//           i_raddr  read address
//           o_rdata  read data, combinational from i_raddr
// Macros  : none
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module mem_array #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  wire              clock,
   input  wire              i_we,
   input  wire [ADDR_W-1:0] i_waddr,
   input  wire [DATA_W-1:0] i_wdata,
   input  wire [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   localparam int c_depth = 2 ** ADDR_W;

   logic [DATA_W-1:0] r_mem [c_depth];

   always_ff @(posedge clock) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // A write is visible on the read port from the cycle after its posedge.
   assign o_rdata = r_mem[i_raddr];

endmodule : mem_array
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : mem_responder
// Purpose : Memory-side responder for the controller bus. After reset it
//           fills the whole array with FILL_BYTE, then accepts a program
//           image over the byte-stream load port, then serves controller
//           reads (asynchronous) and writes (one per rising strobe edge).
// Ports   : clock  system clock, all state updates on posedge
//           reset  synchronous active-high reset
//           bus    mem_responder_if.slave (controller bus + load stream)
// Macros  : MEM_WP_EN - when defined, controller writes below WP_LIMIT are
//           dropped and flag a sticky wp_fault; otherwise wp_fault is 0.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module mem_responder
   import mem_pkg::*;
#(
   parameter int                ADDR_W    = 8,
   parameter int                DATA_W    = 8,
   parameter logic [DATA_W-1:0] FILL_BYTE = DATA_W'(c_default_fill_byte),
   parameter logic [ADDR_W-1:0] WP_LIMIT  = ADDR_W'(c_default_wp_limit)
) (
   input  wire            clock,
   input  wire            reset,
   mem_responder_if.slave bus
);

   localparam logic [ADDR_W-1:0] c_last_addr = '1;

   mem_state_t        r_state;
   mem_state_t        w_next_state;
   logic [ADDR_W-1:0] r_fill_ptr;
   logic [ADDR_W-1:0] r_load_ptr;
   logic              r_strobe_q;

   logic              w_access;
   logic              w_below_limit;
   logic              w_wp_block;
   logic              w_wp_hit;
   logic              w_we;
   logic [ADDR_W-1:0] w_waddr;
   logic [DATA_W-1:0] w_wdata;
   logic [DATA_W-1:0] w_rdata;
   logic              w_load_ready;
   logic              w_mem_ready;

   // An access is the rising edge of the level strobe, so a strobe held high
   // for several cycles produces exactly one write.
   assign w_access      = bus.mem_clock & ~r_strobe_q;
   assign w_below_limit = (bus.address < WP_LIMIT);

`ifdef MEM_WP_EN
   logic r_wp_fault;

   assign w_wp_block = w_below_limit;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_wp_fault <= 1'b0;
      end else if (w_wp_hit) begin
         r_wp_fault <= 1'b1;
      end
   end

   assign bus.wp_fault = r_wp_fault;
`else
   logic w_unused_wp;

   assign w_wp_block   = 1'b0;
   assign w_unused_wp  = w_below_limit | w_wp_hit;
   assign bus.wp_fault = 1'b0;
`endif

   //---------------------------------------------------------------------------
   // State register and pointers
   //---------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= ST_CLEAR;
         r_fill_ptr <= '0;
         r_load_ptr <= '0;
         r_strobe_q <= 1'b0;
      end else begin
         r_state <= w_next_state;
         case (r_state)
            ST_CLEAR: begin
               // Wraps back to 0 on the last fill write, leaving it clean.
               r_fill_ptr <= r_fill_ptr + 1'b1;
               r_load_ptr <= '0;
            end
            ST_LOAD: begin
               if (bus.load_valid) begin
                  r_load_ptr <= r_load_ptr + 1'b1;
               end
            end
            ST_SERVE: begin
               r_strobe_q <= bus.mem_clock;
            end
            default: begin
               r_strobe_q <= 1'b0;
            end
         endcase
      end
   end

   //---------------------------------------------------------------------------
   // Next state and write-port multiplexer
   //---------------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      w_we         = 1'b0;
      w_waddr      = r_fill_ptr;
      w_wdata      = FILL_BYTE;
      w_load_ready = 1'b0;
      w_mem_ready  = 1'b0;
      w_wp_hit     = 1'b0;

      case (r_state)
         ST_CLEAR: begin
            w_we = 1'b1;
            if (r_fill_ptr == c_last_addr) begin
               w_next_state = ST_LOAD;
            end
         end

         ST_LOAD: begin
            w_load_ready = 1'b1;
            w_waddr      = r_load_ptr;
            w_wdata      = bus.load_data;
            if (bus.load_valid) begin
               w_we = 1'b1;
               // Filling the top address ends the load without wrapping onto
               // address 0, whether or not load_last was flagged.
               if (bus.load_last || (r_load_ptr == c_last_addr)) begin
                  w_next_state = ST_SERVE;
               end
            end
         end

         ST_SERVE: begin
            w_mem_ready = 1'b1;
            w_waddr     = bus.address;
            w_wdata     = bus.to_mem;
            if (w_access && bus.mem_write) begin
               if (w_wp_block) begin
                  w_wp_hit = 1'b1;
               end else begin
                  w_we = 1'b1;
               end
            end
         end

         default: begin
            w_next_state = ST_CLEAR;
         end
      endcase
   end

   //---------------------------------------------------------------------------
   // Storage
   //---------------------------------------------------------------------------
   mem_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_mem_array (
      .clock   (clock),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_raddr (bus.address),
      .o_rdata (w_rdata)
   );

   // Until serving, the controller only ever sees the no-op fill byte.
   assign bus.from_mem   = (r_state == ST_SERVE) ? w_rdata : FILL_BYTE;
   assign bus.load_ready = w_load_ready;
   assign bus.mem_ready  = w_mem_ready;

endmodule : mem_responder
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_mem_responder
// Purpose : Self-checking bench for mem_responder. Keeps an array model of
//           the expected memory contents and the expected wp_fault flag.
// Ports   : none
// Macros  : MEM_WP_EN - selects the write-protected expectations.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module tb_mem_responder;

   localparam int         c_depth  = 256;
   localparam logic [7:0] c_fill   = 8'hFF;
   localparam logic [7:0] c_wp_lim = 8'h10;
`ifdef MEM_WP_EN
   localparam bit c_wp = 1'b1;
`else
   localparam bit c_wp = 1'b0;
`endif

   logic clock;
   logic reset;

   mem_responder_if #(.ADDR_W(8), .DATA_W(8)) bus ();

   mem_responder #(
      .ADDR_W    (8),
      .DATA_W    (8),
      .FILL_BYTE (8'hFF),
      .WP_LIMIT  (8'h10)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int         n_cmp;
   int         n_fail;
   logic [7:0] model [c_depth];
   logic       exp_fault;
   int         ld_ptr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic read_check(input logic [7:0] a, input string tag);
      bus.address = a;
      @(negedge clock);
      check(tag, {24'd0, bus.from_mem}, {24'd0, model[a]});
   endtask

   task automatic do_reset();
      reset          = 1'b1;
      bus.load_valid = 1'b0;
      bus.load_last  = 1'b0;
      bus.mem_clock  = 1'b0;
      tick();
      tick();
      check("rst_load_ready", {31'd0, bus.load_ready}, 32'd0);
      check("rst_mem_ready",  {31'd0, bus.mem_ready},  32'd0);
      check("rst_wp_fault",   {31'd0, bus.wp_fault},   32'd0);
      check("rst_from_mem",   {24'd0, bus.from_mem},   {24'd0, c_fill});
      reset = 1'b0;
      for (int i = 0; i < c_depth; i++) model[i] = c_fill;
      exp_fault = 1'b0;
      ld_ptr    = 0;
   endtask

   // Counts posedges until load_ready rises; strobes are thrown at the DUT
   // meanwhile and must have no effect.
   task automatic wait_clear();
      int cycles;
      cycles = 0;
      while (bus.load_ready !== 1'b1 && cycles < 600) begin
         bus.address   = 8'($urandom);
         bus.to_mem    = 8'($urandom);
         bus.mem_clock = 1'($urandom);
         bus.mem_write = 1'b1;
         @(negedge clock);
         check("clear_from_mem", {24'd0, bus.from_mem}, {24'd0, c_fill});
         check("clear_mem_ready", {31'd0, bus.mem_ready}, 32'd0);
         tick();
         cycles++;
      end
      bus.mem_clock = 1'b0;
      check("clear_len", cycles, 32'd256);
   endtask

   task automatic load_byte(input logic [7:0] d, input logic last, input int gaps);
      for (int g = 0; g < gaps; g++) begin
         bus.load_valid = 1'b0;
         bus.load_last  = 1'($urandom);
         bus.load_data  = 8'($urandom);
         bus.mem_clock  = 1'($urandom);
         bus.mem_write  = 1'b1;
         bus.address    = 8'($urandom);
         @(negedge clock);
         check("load_from_mem", {24'd0, bus.from_mem}, {24'd0, c_fill});
         tick();
      end
      bus.mem_clock  = 1'b0;
      bus.load_valid = 1'b1;
      bus.load_data  = d;
      bus.load_last  = last;
      check("load_ready", {31'd0, bus.load_ready}, 32'd1);
      tick();
      bus.load_valid = 1'b0;
      bus.load_last  = 1'b0;
      model[ld_ptr]  = d;
      ld_ptr++;
   endtask

   // One controller access with the strobe held for 'hold' cycles; to_mem and
   // mem_write are disturbed after the first edge and must not matter.
   task automatic serve_access(input logic [7:0] a, input logic [7:0] d, input logic we, input int hold);
      bus.address   = a;
      bus.to_mem    = d;
      bus.mem_write = we;
      bus.mem_clock = 1'b1;
      tick();
      if (we) begin
         if (c_wp && a < c_wp_lim) exp_fault = 1'b1;
         else model[a] = d;
      end
      check("wr_then_rd", {24'd0, bus.from_mem}, {24'd0, model[a]});
      for (int h = 1; h < hold; h++) begin
         bus.to_mem    = ~d;
         bus.mem_write = 1'b1;
         tick();
         check("hold_rd", {24'd0, bus.from_mem}, {24'd0, model[a]});
      end
      bus.mem_clock = 1'b0;
      bus.mem_write = 1'($urandom);
      tick();
      check("wp_fault", {31'd0, bus.wp_fault}, {31'd0, exp_fault});
   endtask

   initial begin
      n_cmp = 0;
      n_fail = 0;
      bus.address = '0; bus.to_mem = '0; bus.mem_clock = 1'b0; bus.mem_write = 1'b0;
      bus.load_valid = 1'b0; bus.load_data = '0; bus.load_last = 1'b0;
      reset = 1'b1;

      // Reset, then a full clear with no load traffic.
      do_reset();
      wait_clear();

      // Short image terminated by load_last.
      load_byte(8'hC5, 1'b0, int'($urandom_range(0, 2)));
      load_byte(8'hD8, 1'b0, int'($urandom_range(0, 2)));
      check("pre_last_mem_ready", {31'd0, bus.mem_ready}, 32'd0);
      load_byte(8'hE0, 1'b1, int'($urandom_range(0, 2)));
      check("post_last_mem_ready", {31'd0, bus.mem_ready}, 32'd1);
      check("post_last_load_ready", {31'd0, bus.load_ready}, 32'd0);
      for (int i = 0; i < 4; i++) read_check(8'(i), "img_rd");

      // Strobe held for three cycles, data changed mid-strobe: one write.
      bus.address = 8'h20; bus.to_mem = 8'h5A; bus.mem_write = 1'b1; bus.mem_clock = 1'b1;
      tick();
      model[8'h20] = 8'h5A;
      check("strobe_c1", {24'd0, bus.from_mem}, 32'h5A);
      bus.to_mem = 8'h77;
      tick();
      check("strobe_c2", {24'd0, bus.from_mem}, 32'h5A);
      tick();
      check("strobe_c3", {24'd0, bus.from_mem}, 32'h5A);
      bus.mem_clock = 1'b0;
      tick();
      read_check(8'h20, "strobe_rd");

      // Random controller traffic against the model.
      for (int k = 0; k < 60; k++)
         serve_access(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(1, 3)));
      for (int k = 0; k < 20; k++) read_check(8'($urandom), "rand_rd");

      // Write-protect boundary: just inside and at the limit.
      serve_access(8'h05, 8'h33, 1'b1, 1);
      serve_access(8'h10, 8'h44, 1'b1, 2);
      read_check(8'h05, "wp_rd_05");
      read_check(8'h10, "wp_rd_10");
      repeat (3) tick();
      check("wp_fault_held", {31'd0, bus.wp_fault}, {31'd0, exp_fault});

      // Full 256-byte image with no load_last.
      do_reset();
      wait_clear();
      for (int i = 0; i < c_depth; i++) begin
         if (i == c_depth - 1)
            check("full_pre_mem_ready", {31'd0, bus.mem_ready}, 32'd0);
         load_byte(8'(i), 1'b0, int'($urandom_range(0, 1)));
      end
      check("full_mem_ready", {31'd0, bus.mem_ready}, 32'd1);
      check("full_load_ready", {31'd0, bus.load_ready}, 32'd0);
      read_check(8'h00, "full_rd_00");
      read_check(8'hFF, "full_rd_ff");
      for (int k = 0; k < 10; k++) read_check(8'($urandom), "full_rd");

      // Reset in the middle of a load.
      do_reset();
      wait_clear();
      for (int i = 0; i < 40; i++) load_byte(8'(i + 1), 1'b0, 0);
      bus.load_valid = 1'b1;
      bus.load_data  = 8'h99;
      do_reset();
      wait_clear();
      load_byte(8'hAA, 1'b1, 1);
      check("reload_mem_ready", {31'd0, bus.mem_ready}, 32'd1);
      read_check(8'h00, "reload_rd_00");
      read_check(8'h01, "reload_rd_01");
      read_check(8'h27, "reload_rd_27");
      read_check(8'h28, "reload_rd_28");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_mem_responder
`default_nettype wire
